// File: rtl/ms_time_split_pkg.sv
// Shared constants, field widths and state/pass encodings for the millisecond
// to days/hours/minutes/seconds/millis converter.
package ms_time_split_pkg;

    localparam int unsigned MS_PER_S  = 1000;
    localparam int unsigned S_PER_MIN = 60;
    localparam int unsigned MIN_PER_H = 60;
    localparam int unsigned H_PER_DAY = 24;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MS_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        P_MS   = 2'd0,
        P_SEC  = 2'd1,
        P_MIN  = 2'd2,
        P_HOUR = 2'd3
    } pass_e;

    // Divisor applied during each of the four division passes.
    function automatic int unsigned pass_divisor(input pass_e p);
        case (p)
            P_MS:    return MS_PER_S;
            P_SEC:   return S_PER_MIN;
            P_MIN:   return MIN_PER_H;
            default: return H_PER_DAY;
        endcase
    endfunction

endpackage

// File: rtl/ms_time_split_serial_div.sv
// Restoring divider, one quotient bit per cycle MSB first; the start edge
// already resolves bit W-1, so a division occupies exactly W edges.
module serial_div #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned BW = $clog2(W);

    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [BW-1:0] idx_c;
    logic          in_bit_c;
    logic [W:0]    shifted_c;
    logic [W:0]    dsr_ext_c;
    logic          ge_c;

    always_comb begin
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        done_d = 1'b0;

        idx_c     = start ? BW'(W - 1) : bit_q;
        in_bit_c  = start ? dividend[idx_c] : dvd_q[idx_c];
        shifted_c = start ? {W'(0), in_bit_c} : {rem_q, in_bit_c};
        dsr_ext_c = {1'b0, (start ? divisor : dsr_q)};
        ge_c      = (shifted_c >= dsr_ext_c);

        if (start || busy_q) begin
            // Remainder stays below the divisor, so W bits hold it after the step.
            rem_d        = ge_c ? W'(shifted_c - dsr_ext_c) : W'(shifted_c);
            quo_d        = start ? '0 : quo_q;
            quo_d[idx_c] = ge_c;
            if (start) begin
                dvd_d = dividend;
                dsr_d = divisor;
            end
            if (idx_c == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
                bit_d  = idx_c - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ms_time_split.sv
// Splits a running millisecond total into days/hours/minutes/seconds/millis
// using four back-to-back passes of one shared serial divider.
module ms_time_split
    import ms_time_split_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DAY_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  nrms_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DAY_W-1:0]  days,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MS_W-1:0]   millis
);

    state_e            state_q, state_d;
    pass_e             pass_q, pass_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [MS_W-1:0]   ms_sh_q, ms_sh_d;
    logic [SEC_W-1:0]  sec_sh_q, sec_sh_d;
    logic [MIN_W-1:0]  min_sh_q, min_sh_d;
    logic [DAY_W-1:0]  days_q, days_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [SEC_W-1:0]  seconds_q, seconds_d;
    logic [MS_W-1:0]   millis_q, millis_d;

    logic              div_start_c;
    pass_e             div_sel_c;
    logic [CNT_W-1:0]  div_dividend_c;
    logic [CNT_W-1:0]  div_divisor_c;
    logic              div_busy;
    logic              div_done;
    logic [CNT_W-1:0]  div_quo;
    logic [CNT_W-1:0]  div_rem;
    logic              unused_div_c;

    assign div_divisor_c = CNT_W'(pass_divisor(div_sel_c));
    assign unused_div_c  = ^{div_busy, div_rem[CNT_W-1:MS_W]};

    serial_div #(
        .W (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_c),
        .dividend  (div_dividend_c),
        .divisor   (div_divisor_c),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Handshake FSM and pass sequencing; the next pass launches in the same
    // cycle the previous one reports done, keeping latency at 4*CNT_W.
    always_comb begin
        state_d        = state_q;
        pass_d         = pass_q;
        in_ready_d     = in_ready_q;
        out_valid_d    = out_valid_q;
        ms_sh_d        = ms_sh_q;
        sec_sh_d       = sec_sh_q;
        min_sh_d       = min_sh_q;
        days_d         = days_q;
        hours_d        = hours_q;
        minutes_d      = minutes_q;
        seconds_d      = seconds_q;
        millis_d       = millis_q;
        div_start_c    = 1'b0;
        div_sel_c      = P_MS;
        div_dividend_c = div_quo;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_start_c    = 1'b1;
                    div_dividend_c = nrms_in;
                    pass_d         = P_MS;
                    in_ready_d     = 1'b0;
                    state_d        = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    case (pass_q)
                        P_MS:  ms_sh_d  = div_rem[MS_W-1:0];
                        P_SEC: sec_sh_d = div_rem[SEC_W-1:0];
                        P_MIN: min_sh_d = div_rem[MIN_W-1:0];
                        default: begin
                            hours_d     = div_rem[HOUR_W-1:0];
                            days_d      = div_quo[DAY_W-1:0];
                            millis_d    = ms_sh_q;
                            seconds_d   = sec_sh_q;
                            minutes_d   = min_sh_q;
                            out_valid_d = 1'b1;
                            pass_d      = P_MS;
                            state_d     = DONE;
                        end
                    endcase
                    if (pass_q != P_HOUR) begin
                        div_sel_c   = pass_e'(pass_q + 2'd1);
                        div_start_c = 1'b1;
                        pass_d      = div_sel_c;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pass_q      <= P_MS;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ms_sh_q     <= '0;
            sec_sh_q    <= '0;
            min_sh_q    <= '0;
            days_q      <= '0;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            millis_q    <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ms_sh_q     <= ms_sh_d;
            sec_sh_q    <= sec_sh_d;
            min_sh_q    <= min_sh_d;
            days_q      <= days_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            millis_q    <= millis_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign days      = days_q;
    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign millis    = millis_q;

endmodule

// File: doc/ms_time_split.md
Name: ms_time_split

Overview:
- Sits directly downstream of the millisecond counter. It consumes the counter's 32-bit running millisecond total.
- Converts the total into days, hours, minutes, seconds and milliseconds for the display/formatting stage.
- Uses a valid/ready handshake on both sides.
- Uses one shared serial restoring divider run in four passes: /1000, /60, /60, /24.

Parameters:
- CNT_W, 32, width of the millisecond count input and of the internal divider datapath.
- DAY_W, 6, width of the days output. The final quotient is truncated to DAY_W bits; 6 covers 49 days at CNT_W=32.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  nrms_in is valid and conversion is requested
- in_ready  out  1  block can accept a new count
- nrms_in  in  CNT_W  millisecond count to convert
- out_valid  out  1  result fields are valid
- out_ready  in  1  consumer accepts the result
- days  out  DAY_W  whole days
- hours  out  5  0..23
- minutes  out  6  0..59
- seconds  out  6  0..59
- millis  out  10  0..999

Behaviour:
- Reset (async, immediate):
  - state=IDLE, in_ready=1, out_valid=0.
  - All result outputs 0; divider registers and pass counters 0.
  - Reset mid-conversion aborts the conversion with no partial output.
- States: IDLE, DIV, DONE.
  - IDLE: in_ready=1. On in_valid at an edge, latch nrms_in into the dividend, set pass=0, bit=CNT_W-1, go to DIV. nrms_in is ignored after the accepting edge.
  - DIV: in_ready=0, one quotient bit per cycle, MSB first.
    - rem' = {rem, dividend[bit]}.
    - If rem' >= divisor: rem'=rem'-divisor, q[bit]=1.
    - Remainder width CNT_W+1 to avoid overflow.
  - Pass divisors: pass0=1000, pass1=60, pass2=60, pass3=24.
  - End of each pass (bit==0 processed):
    - pass0: millis<=rem[9:0], next dividend=q.
    - pass1: seconds<=rem[5:0], next dividend=q.
    - pass2: minutes<=rem[5:0], next dividend=q.
    - pass3: hours<=rem[4:0], days<=q[DAY_W-1:0], go to DONE.
    - On every pass change, clear rem and reset bit to CNT_W-1.
  - Result fields are written into internal shadow registers during DIV. Visible outputs update only on entry to DONE, so outputs never show partial results.
  - DONE: out_valid=1, fields stable. On out_ready go to IDLE. out_valid falls on that edge; fields hold their values until the next DONE entry.
- Latency: out_valid is high exactly 4*CNT_W cycles after the accepting edge (128 at default). Latency is fixed and independent of data.
- No pipelining: in_ready is low in DIV and DONE. A new request can be accepted no earlier than the edge after the out handshake.
- Simultaneous events:
  - in_valid held high across DONE->IDLE is accepted on the first IDLE edge.
  - out_ready asserted before out_valid has no effect.
- Arithmetic: all subtraction is unsigned. Maximum input 2^CNT_W-1 must convert correctly; no saturation below the DAY_W truncation.

Decomposition:
- Shared package (time_pkg):
  - divisor constants MS_PER_S=1000, S_PER_MIN=60, MIN_PER_H=60, H_PER_DAY=24
  - state enum IDLE/DIV/DONE
  - output field widths (5/6/6/10)
- Sub-module serial_div:
  - Parameter W; ports clk, rst, start, dividend[W], divisor[W], busy, done pulse, quotient[W], remainder[W].
  - One bit per cycle, W cycles per division.
- ms_time_split owns the handshake FSM, pass sequencing, divisor selection and result registers.

Test Plan:
- nrms_in=0 -> after 128 cycles: out_valid=1, all fields 0.
- nrms_in=3_723_004 -> d=0 h=1 m=2 s=3 ms=4, out_valid exactly 128 cycles after accept.
- nrms_in=86_399_999 -> d=0 h=23 m=59 s=59 ms=999. Then nrms_in=86_400_000 -> d=1, other fields 0.
- nrms_in=32'hFFFF_FFFF -> d=49 h=17 m=2 s=47 ms=295.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid -> fields and out_valid stable, in_ready=0. Raise out_ready with in_valid held high -> next request accepted on the following edge.
- Assert rst at cycle 60 of a conversion -> in_ready=1, out_valid=0, fields 0 immediately. A fresh request afterwards yields the correct result.
